// File: rtl/hd_controller.sv
// Multi-cycle secondary-storage unit: serves disk-load/store instructions and
// freezes the core through hd_stall until the access completes.
module hd_controller #(
   parameter int TRACKS        = 16,
   parameter int SECTORS       = 8,
   parameter int TRACK_W       = 4,
   parameter int SECTOR_W      = 4,
   parameter int ACCESS_CYCLES = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                hd_read,
   input  logic                hd_write,
   input  logic [TRACK_W-1:0]  track,
   input  logic [SECTOR_W-1:0] sector,
   input  logic [31:0]         data_in,
   output logic [31:0]         data_HD,
   output logic                hd_stall,
   output logic                hd_done,
   output logic                hd_error
);

   localparam int WORDS = TRACKS * SECTORS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_op_wr;
   logic [IDX_W-1:0]   r_idx;
   logic [31:0]        r_wdata;
   logic [31:0]        r_data_hd;
   logic               r_done;
   logic               r_error;
   logic [31:0]        r_mem [WORDS];

   logic               w_req;
   logic               w_one_op;
   logic               w_in_range;
   logic               w_legal;
   logic               w_illegal;
   logic               w_commit;
   logic               w_stall;
   logic [IDX_W-1:0]   w_idx;

   function automatic logic [IDX_W-1:0] lin_index(input logic [TRACK_W-1:0]  trk,
                                                  input logic [SECTOR_W-1:0] sec);
      lin_index = IDX_W'(int'(trk) * SECTORS + int'(sec));
   endfunction

   // Request classification in the IDLE state
   always_comb begin
      w_req      = hd_read | hd_write;
      w_one_op   = hd_read ^ hd_write;
      w_in_range = (int'(track) < TRACKS) && (int'(sector) < SECTORS);
      w_legal    = w_one_op && w_in_range;
      w_illegal  = w_req && !w_legal;
      w_idx      = lin_index(track, sector);
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_legal) begin
               w_next = S_BUSY;
            end else if (w_illegal) begin
               w_next = S_DONE;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_BUSY: begin
            if (r_cnt == CNT_W'(0)) begin
               w_next = S_DONE;
            end else begin
               w_next = S_BUSY;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Stall is combinational so the core freezes in the same cycle it issues
   always_comb begin
      w_stall  = 1'b0;
      w_commit = 1'b0;
      case (r_state)
         S_IDLE:  w_stall = w_req;
         S_BUSY: begin
            w_stall  = 1'b1;
            w_commit = (r_cnt == CNT_W'(0));
         end
         S_DONE:  w_stall = 1'b0;
         default: w_stall = 1'b0;
      endcase
   end

   // Request latch, countdown, read return and status flags
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt     <= CNT_W'(0);
         r_op_wr   <= 1'b0;
         r_idx     <= IDX_W'(0);
         r_wdata   <= 32'h0000_0000;
         r_data_hd <= 32'h0000_0000;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_done <= (w_next == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (w_legal) begin
                  r_op_wr <= hd_write;
                  r_idx   <= w_idx;
                  r_wdata <= data_in;
                  r_cnt   <= CNT_LOAD;
                  r_error <= 1'b0;
               end else if (w_illegal) begin
                  r_error <= 1'b1;
               end
            end
            S_BUSY: begin
               if (r_cnt != CNT_W'(0)) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else if (!r_op_wr) begin
                  r_data_hd <= r_mem[r_idx];
               end
            end
            S_DONE: begin
               r_cnt <= CNT_W'(0);
            end
            default: begin
               r_cnt <= CNT_W'(0);
            end
         endcase
      end
   end

   // Storage array; deliberately not cleared by reset
   always_ff @(posedge clock) begin
      if (!reset && w_commit && r_op_wr) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   assign data_HD  = r_data_hd;
   assign hd_stall = w_stall;
   assign hd_done  = r_done;
   assign hd_error = r_error;

endmodule

// File: tb/tb_hd_controller.sv
// Self-checking bench for hd_controller: directed scenarios plus randomized
// accesses checked against an array-based model of the disk.
module tb_hd_controller;

   localparam int AC = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        hd_read;
   logic        hd_write;
   logic [3:0]  track;
   logic [3:0]  sector;
   logic [31:0] data_in;
   logic [31:0] data_HD;
   logic        hd_stall;
   logic        hd_done;
   logic        hd_error;

   int checks = 0;
   int failures = 0;
   int done_total = 0;

   logic [31:0] mem_m [128];
   logic [31:0] dhd_m;
   logic        err_m;

   hd_controller #(
      .TRACKS(16), .SECTORS(8), .TRACK_W(4), .SECTOR_W(4), .ACCESS_CYCLES(AC)
   ) dut (
      .clock(clock), .reset(reset), .hd_read(hd_read), .hd_write(hd_write),
      .track(track), .sector(sector), .data_in(data_in), .data_HD(data_HD),
      .hd_stall(hd_stall), .hd_done(hd_done), .hd_error(hd_error)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (hd_done === 1'b1) done_total++;
   end

   // Model: returns expected stall cycles and updates the modelled state
   function automatic int model_apply(input logic rd, input logic wr,
                                      input logic [3:0] trk, input logic [3:0] sec,
                                      input logic [31:0] din);
      bit legal;
      int idx;
      legal = (rd != wr) && (int'(trk) < 16) && (int'(sec) < 8);
      if (legal) begin
         idx = int'(trk) * 8 + int'(sec);
         err_m = 1'b0;
         if (rd) dhd_m = mem_m[idx];
         else    mem_m[idx] = din;
         return 1 + AC;
      end
      err_m = 1'b1;
      return 1;
   endfunction

   // Drives one request from the start of an IDLE cycle until the cycle after hd_done
   task automatic do_access(input logic rd, input logic wr, input logic [3:0] trk,
                            input logic [3:0] sec, input logic [31:0] din,
                            input bit hold, input bit scramble,
                            output int n_stall, output int n_done,
                            output logic [31:0] dhd, output logic err);
      n_stall = 0;
      n_done  = 0;
      dhd     = 32'h0;
      err     = 1'b0;
      hd_read = rd; hd_write = wr; track = trk; sector = sec; data_in = din;
      for (int c = 0; c < 20 && n_done == 0; c++) begin
         @(negedge clock);
         if (hd_stall === 1'b1) n_stall++;
         if (hd_done === 1'b1) begin
            n_done++;
            dhd = data_HD;
            err = hd_error;
         end
         @(posedge clock); #1;
         if (scramble) begin
            track   = 4'($urandom);
            sector  = 4'($urandom);
            data_in = $urandom;
         end
      end
      if (!hold) begin
         hd_read  = 1'b0;
         hd_write = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; hd_read = 1'b0; hd_write = 1'b0;
      track = 4'd0; sector = 4'd0; data_in = 32'h0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      dhd_m = 32'h0; err_m = 1'b0;
      @(negedge clock);
      checks++; if (data_HD !== 32'h0) begin failures++; $display("FAIL rst_data: got %h expected 0", data_HD); end
      checks++; if (hd_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", hd_done); end
      checks++; if (hd_error !== 1'b0) begin failures++; $display("FAIL rst_error: got %b expected 0", hd_error); end
      checks++; if (hd_stall !== 1'b0) begin failures++; $display("FAIL rst_stall: got %b expected 0", hd_stall); end
      @(posedge clock); #1;
   endtask

   task automatic test_preload();
      int ns, nd, exp, bad;
      logic [31:0] dhd; logic err;
      bad = 0;
      for (int i = 0; i < 128; i++) begin
         exp = model_apply(1'b0, 1'b1, 4'(i / 8), 4'(i % 8), $urandom);
         do_access(1'b0, 1'b1, 4'(i / 8), 4'(i % 8), mem_m[i], 1'b0, 1'b0, ns, nd, dhd, err);
         if (ns != exp || nd != 1 || err !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL preload: got %0d bad writes expected 0", bad); end
      checks++; if (data_HD !== 32'h0) begin failures++; $display("FAIL preload_data: got %h expected 0", data_HD); end
   endtask

   task automatic test_write_read();
      int ns, nd, exp, bad;
      logic [31:0] dhd; logic err;
      exp = model_apply(1'b0, 1'b1, 4'd3, 4'd5, 32'hDEAD_BEEF);
      do_access(1'b0, 1'b1, 4'd3, 4'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, ns, nd, dhd, err);
      checks++; if (ns != 5 || exp != 5) begin failures++; $display("FAIL wr_stall: got %0d expected 5", ns); end
      checks++; if (nd != 1) begin failures++; $display("FAIL wr_done: got %0d expected 1", nd); end
      checks++; if (dhd !== 32'h0) begin failures++; $display("FAIL wr_data_hd: got %h expected 0", dhd); end
      exp = model_apply(1'b1, 1'b0, 4'd3, 4'd5, 32'h0);
      do_access(1'b1, 1'b0, 4'd3, 4'd5, 32'h0, 1'b0, 1'b0, ns, nd, dhd, err);
      checks++; if (ns != exp) begin failures++; $display("FAIL rd_stall: got %0d expected %0d", ns, exp); end
      checks++; if (dhd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data: got %h expected deadbeef", dhd); end
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (data_HD !== 32'hDEAD_BEEF || hd_done !== 1'b0) bad++;
         @(posedge clock); #1;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL rd_hold: got %0d bad cycles expected 0", bad); end
   endtask

   task automatic test_out_of_range();
      int ns, nd, exp;
      logic [31:0] dhd; logic err;
      exp = model_apply(1'b1, 1'b0, 4'd2, 4'd9, 32'h0);
      do_access(1'b1, 1'b0, 4'd2, 4'd9, 32'h0, 1'b0, 1'b0, ns, nd, dhd, err);
      checks++; if (ns != exp) begin failures++; $display("FAIL oor_stall: got %0d expected %0d", ns, exp); end
      checks++; if (nd != 1) begin failures++; $display("FAIL oor_done: got %0d expected 1", nd); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_error: got %b expected 1", err); end
      checks++; if (dhd !== dhd_m) begin failures++; $display("FAIL oor_data: got %h expected %h", dhd, dhd_m); end
      exp = model_apply(1'b1, 1'b0, 4'd4, 4'd1, 32'h0);
      do_access(1'b1, 1'b0, 4'd4, 4'd1, 32'h0, 1'b0, 1'b0, ns, nd, dhd, err);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL oor_clear: got %b expected 0", err); end
      checks++; if (dhd !== dhd_m) begin failures++; $display("FAIL oor_next_rd: got %h expected %h", dhd, dhd_m); end
   endtask

   task automatic test_both();
      int ns, nd, exp;
      logic [31:0] dhd; logic err;
      exp = model_apply(1'b0, 1'b1, 4'd0, 4'd0, 32'h55AA_55AA);
      do_access(1'b0, 1'b1, 4'd0, 4'd0, 32'h55AA_55AA, 1'b0, 1'b0, ns, nd, dhd, err);
      exp = model_apply(1'b1, 1'b1, 4'd0, 4'd0, 32'hFFFF_FFFF);
      do_access(1'b1, 1'b1, 4'd0, 4'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, ns, nd, dhd, err);
      checks++; if (ns != exp) begin failures++; $display("FAIL both_stall: got %0d expected %0d", ns, exp); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL both_error: got %b expected 1", err); end
      checks++; if (hd_error !== 1'b1) begin failures++; $display("FAIL both_err_hold: got %b expected 1", hd_error); end
      exp = model_apply(1'b1, 1'b0, 4'd0, 4'd0, 32'h0);
      do_access(1'b1, 1'b0, 4'd0, 4'd0, 32'h0, 1'b0, 1'b0, ns, nd, dhd, err);
      checks++; if (dhd !== 32'h55AA_55AA) begin failures++; $display("FAIL both_word0: got %h expected 55aa55aa", dhd); end
   endtask

   task automatic test_reset_mid();
      int ns, nd, exp;
      logic [31:0] dhd; logic err;
      exp = model_apply(1'b0, 1'b1, 4'd15, 4'd7, 32'h0BAD_F00D);
      do_access(1'b0, 1'b1, 4'd15, 4'd7, 32'h0BAD_F00D, 1'b0, 1'b0, ns, nd, dhd, err);
      hd_write = 1'b1; hd_read = 1'b0; track = 4'd15; sector = 4'd7; data_in = 32'h1234_5678;
      @(posedge clock); #1;
      @(posedge clock); #1;
      checks++; if (hd_stall !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b expected 1", hd_stall); end
      reset = 1'b1; hd_write = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      dhd_m = 32'h0; err_m = 1'b0;
      @(negedge clock);
      checks++; if (data_HD !== 32'h0) begin failures++; $display("FAIL mid_data: got %h expected 0", data_HD); end
      checks++; if (hd_done !== 1'b0 || hd_error !== 1'b0 || hd_stall !== 1'b0) begin
         failures++; $display("FAIL mid_flags: got %b%b%b expected 000", hd_done, hd_error, hd_stall);
      end
      @(posedge clock); #1;
      exp = model_apply(1'b1, 1'b0, 4'd15, 4'd7, 32'h0);
      do_access(1'b1, 1'b0, 4'd15, 4'd7, 32'h0, 1'b0, 1'b0, ns, nd, dhd, err);
      checks++; if (dhd !== 32'h0BAD_F00D) begin failures++; $display("FAIL mid_word: got %h expected 0badf00d", dhd); end
   endtask

   task automatic test_back_to_back();
      int ns, nd, exp, d0;
      logic [31:0] dhd; logic err;
      exp = model_apply(1'b0, 1'b1, 4'd1, 4'd0, 32'hA);
      do_access(1'b0, 1'b1, 4'd1, 4'd0, 32'hA, 1'b0, 1'b0, ns, nd, dhd, err);
      exp = model_apply(1'b0, 1'b1, 4'd2, 4'd0, 32'hB);
      do_access(1'b0, 1'b1, 4'd2, 4'd0, 32'hB, 1'b0, 1'b0, ns, nd, dhd, err);
      d0 = done_total;
      exp = model_apply(1'b1, 1'b0, 4'd1, 4'd0, 32'h0);
      do_access(1'b1, 1'b0, 4'd1, 4'd0, 32'h0, 1'b1, 1'b0, ns, nd, dhd, err);
      checks++; if (dhd !== 32'hA || ns != exp) begin failures++; $display("FAIL b2b_first: got %h/%0d expected a/%0d", dhd, ns, exp); end
      exp = model_apply(1'b1, 1'b0, 4'd2, 4'd0, 32'h0);
      do_access(1'b1, 1'b0, 4'd2, 4'd0, 32'h0, 1'b0, 1'b0, ns, nd, dhd, err);
      checks++; if (dhd !== 32'hB || ns != exp) begin failures++; $display("FAIL b2b_second: got %h/%0d expected b/%0d", dhd, ns, exp); end
      repeat (5) @(posedge clock);
      #1;
      checks++; if (done_total - d0 != 2) begin failures++; $display("FAIL b2b_pulses: got %0d expected 2", done_total - d0); end
      checks++; if (data_HD !== 32'hB) begin failures++; $display("FAIL b2b_hold: got %h expected b", data_HD); end
   endtask

   task automatic test_random();
      int ns, nd, exp, sel;
      logic rd, wr;
      logic [3:0] trk, sec;
      logic [31:0] din, dhd;
      logic err;
      for (int n = 0; n < 60; n++) begin
         sel = $urandom_range(0, 5);
         rd  = (sel <= 2) || (sel == 5);
         wr  = (sel >= 3);
         trk = 4'($urandom_range(0, 15));
         sec = 4'($urandom_range(0, 9));
         din = $urandom;
         exp = model_apply(rd, wr, trk, sec, din);
         do_access(rd, wr, trk, sec, din, 1'b0, 1'b1, ns, nd, dhd, err);
         checks++; if (ns != exp) begin failures++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", n, ns, exp); end
         checks++; if (nd != 1) begin failures++; $display("FAIL rnd_done[%0d]: got %0d expected 1", n, nd); end
         checks++; if (dhd !== dhd_m) begin failures++; $display("FAIL rnd_data[%0d]: got %h expected %h", n, dhd, dhd_m); end
         checks++; if (err !== err_m) begin failures++; $display("FAIL rnd_error[%0d]: got %b expected %b", n, err, err_m); end
      end
   endtask

   initial begin
      test_reset();
      test_preload();
      test_write_read();
      test_out_of_range();
      test_both();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
